page_stream_adapter: RTL and testbench
======================================

Name: page_stream_adapter

Overview:
- Parametrised buffering adapter between a page's leaf_interface user-side ports and an HLS kernel's AXI-stream ports.
- Supports NUM_IN_PORTS input channels and NUM_OUT_PORTS output channels, each decoupled by its own FIFO.
- Adds an ap_start run/drain state machine and a saturating ap_done counter, replacing the hard-tied ap_start of first-generation pages.
- Sits inside a page wrapper, between the leaf_interface instance and the user kernel.

Parameters:
- PAYLOAD_BITS, 32: data width per channel.
- NUM_IN_PORTS, 1: interface-to-kernel channels (1..8).
- NUM_OUT_PORTS, 1: kernel-to-interface channels (1..8).
- FIFO_ADDR_BITS, 2: log2 of per-channel FIFO depth; depth = 2**FIFO_ADDR_BITS (4 by default).

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run request for the kernel.
- dout_leaf_interface2user  in  NUM_IN_PORTS*PAYLOAD_BITS  data from leaf_interface; channel i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
- vld_interface2user  in  NUM_IN_PORTS  per-channel valid from leaf_interface.
- ack_user2interface  out  NUM_IN_PORTS  per-channel ready to leaf_interface.
- in_tdata  out  NUM_IN_PORTS*PAYLOAD_BITS  to kernel Input_i_V_TDATA.
- in_tvalid  out  NUM_IN_PORTS  to kernel Input_i_V_TVALID.
- in_tready  in  NUM_IN_PORTS  from kernel Input_i_V_TREADY.
- out_tdata  in  NUM_OUT_PORTS*PAYLOAD_BITS  from kernel Output_i_V_TDATA.
- out_tvalid  in  NUM_OUT_PORTS  from kernel Output_i_V_TVALID.
- out_tready  out  NUM_OUT_PORTS  to kernel Output_i_V_TREADY.
- din_leaf_user2interface  out  NUM_OUT_PORTS*PAYLOAD_BITS  data to leaf_interface.
- vld_user2interface  out  NUM_OUT_PORTS  valid to leaf_interface.
- ack_interface2user  in  NUM_OUT_PORTS  ready from leaf_interface.
- ap_start  out  1  kernel start.
- ap_done  in  1  kernel done pulse.
- ap_idle  in  1  kernel idle.
- done_count  out  16  number of ap_done pulses seen, saturating.
- state  out  2  FSM state: 0 IDLE, 1 RUN, 2 DRAIN.
- stall_count  out  NUM_IN_PORTS*16  per-input-channel stall cycles (see Optional Feature).

Behaviour:
Handshakes and FIFOs
- All handshakes are valid/ready: a transfer occurs on a rising clk edge where valid && ready.
- Every channel, input or output, has an independent synchronous FIFO of depth 2**FIFO_ADDR_BITS.
- Read/write pointers are FIFO_ADDR_BITS+1 bits wide; wrap-around is natural and full/empty are derived from the pointer MSB compare.
- Upstream ready (ack_user2interface[i], out_tready[j]) = !full. It depends only on registered state, never on downstream ready.
  - When full, no push is accepted, even if a pop occurs in the same cycle.
- Downstream valid (in_tvalid[i], vld_user2interface[j]) = !empty. Data is the FIFO head.
- No fall-through path: a word pushed at edge N is first visible downstream in the cycle after edge N, i.e. 1-cycle latency.
- Simultaneous push and pop when neither full nor empty: occupancy is unchanged. Throughput is 1 word/cycle per channel.
- Data stays stable while valid && !ready. FIFO order is strictly preserved per channel; channels are fully independent.

FSM
- IDLE: ap_start=0.
  - IDLE -> RUN when enable=1.
- RUN: ap_start=1.
  - RUN -> DRAIN when enable=0.
- DRAIN: ap_start=0.
  - DRAIN -> IDLE when all input FIFOs are empty && ap_idle=1.
  - DRAIN -> RUN if enable returns to 1 before that condition is met.
- FIFOs accept and deliver data in every state; the FSM gates only ap_start.

done_count
- Increments by 1 on each cycle with ap_done=1, in any state.
- Saturates at 16'hFFFF.

Reset
- Asynchronous assertion (reset_n=0) clears all pointers, so every FIFO is empty.
- On reset: state=IDLE, ap_start=0, done_count=0, stall_count=0.
- Consequently all tvalid/vld outputs are 0 and all ready outputs are 1 during and after reset.
- Reset mid-transfer discards all buffered words; there is no partial-word state.
- State 3 is unreachable; if entered it returns to IDLE on the next edge.

Optional Feature:
- Macro: PAGE_STREAM_STATS_EN.
- Defined: stall_count[i] increments on each cycle with in_tvalid[i]=1 && in_tready[i]=0, saturating at 16'hFFFF, cleared by reset.
- Undefined: no counter logic is built and stall_count is driven constant 0. The port list is identical in both builds.

Test Plan:
- Reset release, NUM_IN_PORTS=2, all valids 0 -> ack_user2interface=2'b11, in_tvalid=0, state=0, ap_start=0.
- Channel 0: push 0x11,0x22,0x33,0x44 with in_tready=0 -> ack_user2interface[0] falls after the 4th push. Then raise in_tready -> kernel receives 0x11..0x44 in order, one per cycle; ack returns to 1 after the first pop.
- Continuous vld=1 and in_tready=1 for 100 cycles with an incrementing pattern -> 100 words delivered, none lost or duplicated, occupancy constant, tvalid first high 1 cycle after the first push.
- enable=1 -> state=RUN, ap_start=1. Then enable=0 with 2 words queued and ap_idle=0 -> DRAIN until the FIFO is empty and ap_idle=1, then IDLE.
- 70000 ap_done pulses -> done_count=0xFFFF. Assert reset_n=0 mid-stream with 3 words buffered -> tvalid=0 immediately and done_count=0.
- With PAGE_STREAM_STATS_EN: hold in_tvalid[1]=1, in_tready[1]=0 for 10 cycles -> stall_count[1]=10, stall_count[0]=0. Without the macro -> stall_count=0.

Source files
------------

// File: rtl/page_stream_adapter.sv
// page_stream_adapter: buffers each leaf_interface <-> kernel stream channel
// through its own small FIFO and drives ap_start from a run/drain FSM.
// Optional build macro PAGE_STREAM_STATS_EN adds per-input-channel stall
// counters; without it stall_count is tied to zero.

// Single-clock FIFO with registered full/empty (no fall-through path).
module psa_fifo #(
    parameter int W  = 32,
    parameter int AB = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_push_vld,
    input  logic [W-1:0] i_push_data,
    output logic         o_push_rdy,
    output logic         o_pop_vld,
    output logic [W-1:0] o_pop_data,
    input  logic         i_pop_rdy
);
    logic [W-1:0] r_mem [2**AB];
    logic [AB:0]  r_wptr, r_rptr;
    logic         w_full, w_empty, w_push, w_pop;

    // Extra pointer MSB distinguishes full from empty when low bits match.
    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[AB] != r_rptr[AB]) && (r_wptr[AB-1:0] == r_rptr[AB-1:0]);
    assign w_push     = i_push_vld && !w_full;
    assign w_pop      = i_pop_rdy && !w_empty;
    assign o_push_rdy = !w_full;
    assign o_pop_vld  = !w_empty;
    assign o_pop_data = r_mem[r_rptr[AB-1:0]];

    // Storage needs no reset: reset empties the FIFO via the pointers.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AB-1:0]] <= i_push_data;
    end

    // Pointer advance on accepted push / pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end
endmodule

module page_stream_adapter #(
    parameter int PAYLOAD_BITS   = 32,
    parameter int NUM_IN_PORTS   = 1,
    parameter int NUM_OUT_PORTS  = 1,
    parameter int FIFO_ADDR_BITS = 2
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   enable,
    input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]   dout_leaf_interface2user,
    input  logic [NUM_IN_PORTS-1:0]                vld_interface2user,
    output logic [NUM_IN_PORTS-1:0]                ack_user2interface,
    output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]   in_tdata,
    output logic [NUM_IN_PORTS-1:0]                in_tvalid,
    input  logic [NUM_IN_PORTS-1:0]                in_tready,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]  out_tdata,
    input  logic [NUM_OUT_PORTS-1:0]               out_tvalid,
    output logic [NUM_OUT_PORTS-1:0]               out_tready,
    output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]  din_leaf_user2interface,
    output logic [NUM_OUT_PORTS-1:0]               vld_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]               ack_interface2user,
    output logic                                   ap_start,
    input  logic                                   ap_done,
    input  logic                                   ap_idle,
    output logic [15:0]                            done_count,
    output logic [1:0]                             state,
    output logic [NUM_IN_PORTS*16-1:0]             stall_count
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]  r_state;
    logic [15:0] r_done_count;
    logic        w_in_all_empty;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN_PORTS; gi++) begin : g_in
            psa_fifo #(.W(PAYLOAD_BITS), .AB(FIFO_ADDR_BITS)) u_fifo (
                .clk         (clk),
                .reset_n     (reset_n),
                .i_push_vld  (vld_interface2user[gi]),
                .i_push_data (dout_leaf_interface2user[gi*PAYLOAD_BITS +: PAYLOAD_BITS]),
                .o_push_rdy  (ack_user2interface[gi]),
                .o_pop_vld   (in_tvalid[gi]),
                .o_pop_data  (in_tdata[gi*PAYLOAD_BITS +: PAYLOAD_BITS]),
                .i_pop_rdy   (in_tready[gi])
            );
        end
        for (gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_out
            psa_fifo #(.W(PAYLOAD_BITS), .AB(FIFO_ADDR_BITS)) u_fifo (
                .clk         (clk),
                .reset_n     (reset_n),
                .i_push_vld  (out_tvalid[gi]),
                .i_push_data (out_tdata[gi*PAYLOAD_BITS +: PAYLOAD_BITS]),
                .o_push_rdy  (out_tready[gi]),
                .o_pop_vld   (vld_user2interface[gi]),
                .o_pop_data  (din_leaf_user2interface[gi*PAYLOAD_BITS +: PAYLOAD_BITS]),
                .i_pop_rdy   (ack_interface2user[gi])
            );
        end
    endgenerate

    // Input FIFO valid is exactly !empty, so this is "all inputs drained".
    assign w_in_all_empty = ~|in_tvalid;

    // Run/drain FSM; only ap_start depends on it, data flows in every state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (enable) r_state <= S_RUN;
                S_RUN:   if (!enable) r_state <= S_DRAIN;
                S_DRAIN: begin
                    if (w_in_all_empty && ap_idle) r_state <= S_IDLE;
                    else if (enable)               r_state <= S_RUN;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ap_start = (r_state == S_RUN);
    assign state    = r_state;

    // Saturating count of ap_done cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                              r_done_count <= '0;
        else if (ap_done && r_done_count != 16'hFFFF) r_done_count <= r_done_count + 16'd1;
    end

    assign done_count = r_done_count;

`ifdef PAGE_STREAM_STATS_EN
    generate
        for (gi = 0; gi < NUM_IN_PORTS; gi++) begin : g_stall
            logic [15:0] r_stall;
            // Count cycles where the kernel holds off a valid input word.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    r_stall <= '0;
                else if (in_tvalid[gi] && !in_tready[gi] && r_stall != 16'hFFFF)
                    r_stall <= r_stall + 16'd1;
            end
            assign stall_count[gi*16 +: 16] = r_stall;
        end
    endgenerate
`else
    assign stall_count = '0;
`endif
endmodule

// File: tb/tb_page_stream_adapter.sv
// Directed bench for page_stream_adapter: 2 input channels, 1 output channel.
module tb_page_stream_adapter;
    localparam int PB = 32;
    localparam int NI = 2;
    localparam int NO = 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              enable;
    logic [NI*PB-1:0]  dout_leaf_interface2user;
    logic [NI-1:0]     vld_interface2user;
    logic [NI-1:0]     ack_user2interface;
    logic [NI*PB-1:0]  in_tdata;
    logic [NI-1:0]     in_tvalid;
    logic [NI-1:0]     in_tready;
    logic [NO*PB-1:0]  out_tdata;
    logic [NO-1:0]     out_tvalid;
    logic [NO-1:0]     out_tready;
    logic [NO*PB-1:0]  din_leaf_user2interface;
    logic [NO-1:0]     vld_user2interface;
    logic [NO-1:0]     ack_interface2user;
    logic              ap_start;
    logic              ap_done;
    logic              ap_idle;
    logic [15:0]       done_count;
    logic [1:0]        state;
    logic [NI*16-1:0]  stall_count;

    int n_assert = 0;
    int n_fail   = 0;

    page_stream_adapter #(
        .PAYLOAD_BITS(PB), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO), .FIFO_ADDR_BITS(2)
    ) dut (
        .clk                      (clk),
        .reset_n                  (reset_n),
        .enable                   (enable),
        .dout_leaf_interface2user (dout_leaf_interface2user),
        .vld_interface2user       (vld_interface2user),
        .ack_user2interface       (ack_user2interface),
        .in_tdata                 (in_tdata),
        .in_tvalid                (in_tvalid),
        .in_tready                (in_tready),
        .out_tdata                (out_tdata),
        .out_tvalid               (out_tvalid),
        .out_tready               (out_tready),
        .din_leaf_user2interface  (din_leaf_user2interface),
        .vld_user2interface       (vld_user2interface),
        .ack_interface2user       (ack_interface2user),
        .ap_start                 (ap_start),
        .ap_done                  (ap_done),
        .ap_idle                  (ap_idle),
        .done_count               (done_count),
        .state                    (state),
        .stall_count              (stall_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] exp_stall0;
        logic [15:0] exp_stall1;

        reset_n = 1'b0; enable = 1'b0; ap_done = 1'b0; ap_idle = 1'b1;
        dout_leaf_interface2user = '0; vld_interface2user = '0; in_tready = '0;
        out_tdata = '0; out_tvalid = '0; ack_interface2user = '0;

        // Reset state
        tick(); tick();
        check("rst_ack", 64'(ack_user2interface), 64'h3);
        check("rst_tvalid", 64'(in_tvalid), 64'h0);
        reset_n = 1'b1;
        tick();
        check("post_rst_ack", 64'(ack_user2interface), 64'h3);
        check("post_rst_tvalid", 64'(in_tvalid), 64'h0);
        check("post_rst_state", 64'(state), 64'h0);
        check("post_rst_apstart", 64'(ap_start), 64'h0);
        check("post_rst_done", 64'(done_count), 64'h0);
        check("post_rst_stall", 64'(stall_count), 64'h0);
        check("post_rst_outrdy", 64'(out_tready), 64'h1);
        check("post_rst_vldout", 64'(vld_user2interface), 64'h0);

        // Fill channel 0 with kernel stalled
        vld_interface2user[0] = 1'b1;
        dout_leaf_interface2user[31:0] = 32'h11; tick();
        check("fill1_tvalid", 64'(in_tvalid[0]), 64'h1);
        check("fill1_head", 64'(in_tdata[31:0]), 64'h11);
        dout_leaf_interface2user[31:0] = 32'h22; tick();
        dout_leaf_interface2user[31:0] = 32'h33; tick();
        check("fill3_ack", 64'(ack_user2interface[0]), 64'h1);
        dout_leaf_interface2user[31:0] = 32'h44; tick();
        check("fill4_ack", 64'(ack_user2interface[0]), 64'h0);
        check("fill4_ch1_ack", 64'(ack_user2interface[1]), 64'h1);
        // Full FIFO must refuse a further word
        dout_leaf_interface2user[31:0] = 32'h55; tick();
        check("full_hold_head", 64'(in_tdata[31:0]), 64'h11);
`ifdef PAGE_STREAM_STATS_EN
        exp_stall0 = 16'd4;
`else
        exp_stall0 = 16'd0;
`endif
        check("fill_stall0", 64'(stall_count[15:0]), 64'(exp_stall0));
        vld_interface2user[0] = 1'b0;
        in_tready[0] = 1'b1;
        check("drain_0", 64'(in_tdata[31:0]), 64'h11);
        tick();
        check("drain_1", 64'(in_tdata[31:0]), 64'h22);
        check("drain_ack", 64'(ack_user2interface[0]), 64'h1);
        tick();
        check("drain_2", 64'(in_tdata[31:0]), 64'h33);
        tick();
        check("drain_3", 64'(in_tdata[31:0]), 64'h44);
        tick();
        check("drain_empty", 64'(in_tvalid[0]), 64'h0);

        // 100-word continuous stream, one word per cycle
        check("stream_pre_tvalid", 64'(in_tvalid[0]), 64'h0);
        vld_interface2user[0] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            dout_leaf_interface2user[31:0] = 32'(i) + 32'h1000;
            tick();
            check("stream_word", {in_tvalid[0], ack_user2interface[0], in_tdata[31:0]},
                  {1'b1, 1'b1, 32'(i) + 32'h1000});
        end
        vld_interface2user[0] = 1'b0;
        tick();
        check("stream_end_empty", 64'(in_tvalid[0]), 64'h0);
        in_tready[0] = 1'b0;

        // Output channel: kernel to leaf_interface
        out_tvalid = 1'b1; out_tdata = 32'h55; tick();
        check("out_vld", 64'(vld_user2interface), 64'h1);
        out_tdata = 32'h66; tick();
        out_tvalid = 1'b0; ack_interface2user = 1'b1;
        check("out_w0", 64'(din_leaf_user2interface), 64'h55);
        tick();
        check("out_w1", 64'(din_leaf_user2interface), 64'h66);
        tick();
        check("out_empty", 64'(vld_user2interface), 64'h0);
        ack_interface2user = 1'b0;

        // FSM run/drain
        enable = 1'b1; tick();
        check("run_state", 64'(state), 64'h1);
        check("run_apstart", 64'(ap_start), 64'h1);
        vld_interface2user[0] = 1'b1;
        dout_leaf_interface2user[31:0] = 32'hA1; tick();
        dout_leaf_interface2user[31:0] = 32'hA2; tick();
        vld_interface2user[0] = 1'b0;
        enable = 1'b0; ap_idle = 1'b0; tick();
        check("drain_state", 64'(state), 64'h2);
        check("drain_apstart", 64'(ap_start), 64'h0);
        ap_idle = 1'b1; tick();
        check("drain_wait_fifo", 64'(state), 64'h2);
        ap_idle = 1'b0; in_tready[0] = 1'b1; tick(); tick();
        check("drain_fifo_empty", 64'(in_tvalid[0]), 64'h0);
        tick();
        check("drain_wait_idle", 64'(state), 64'h2);
        ap_idle = 1'b1; tick();
        check("back_idle", 64'(state), 64'h0);
        ap_idle = 1'b0;
        enable = 1'b1; tick();
        enable = 1'b0; tick();
        check("drain2_state", 64'(state), 64'h2);
        enable = 1'b1; tick();
        check("drain_to_run", 64'(state), 64'h1);
        enable = 1'b0; ap_idle = 1'b1; tick(); tick();
        check("idle_again", 64'(state), 64'h0);
        in_tready[0] = 1'b0;

        // done_count
        ap_done = 1'b1; tick(); tick(); tick();
        ap_done = 1'b0; tick();
        check("done_3", 64'(done_count), 64'h3);
        ap_done = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        ap_done = 1'b0;
        check("done_sat", 64'(done_count), 64'hFFFF);

        // Asynchronous reset with 3 words buffered on channel 1
        vld_interface2user[1] = 1'b1;
        dout_leaf_interface2user[63:32] = 32'hB1; tick();
        dout_leaf_interface2user[63:32] = 32'hB2; tick();
        dout_leaf_interface2user[63:32] = 32'hB3; tick();
        vld_interface2user[1] = 1'b0;
        check("pre_rst_tvalid", 64'(in_tvalid[1]), 64'h1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_tvalid", 64'(in_tvalid), 64'h0);
        check("async_rst_done", 64'(done_count), 64'h0);
        check("async_rst_ack", 64'(ack_user2interface), 64'h3);
        check("async_rst_stall", 64'(stall_count), 64'h0);
        tick();
        reset_n = 1'b1;
        tick();

        // Stall counter on channel 1
        vld_interface2user[1] = 1'b1;
        dout_leaf_interface2user[63:32] = 32'hC1; tick();
        vld_interface2user[1] = 1'b0;
        repeat (10) tick();
`ifdef PAGE_STREAM_STATS_EN
        exp_stall1 = 16'd10;
`else
        exp_stall1 = 16'd0;
`endif
        check("stall1", 64'(stall_count[31:16]), 64'(exp_stall1));
        check("stall0", 64'(stall_count[15:0]), 64'h0);
        check("stall_head", 64'(in_tdata[63:32]), 64'hC1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
